serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; legal range 2..15.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; captured on the edge that accepts start.
REQ-007 busy  output  1  high from the accepting edge until the result is published.
REQ-008 done  output  1  one-cycle pulse marking a valid result.
REQ-009 q  output  WIDTH  result, (a - b) mod 2^WIDTH.
REQ-010 borrow  output  1  set when a < b (unsigned).
REQ-011 zero  output  1  set when q == 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 SHALL latch a and b into shift registers, clear the borrow flop and the bit counter, and go to SHIFT.
REQ-014 IDLE with start=0 SHALL remain in IDLE.
REQ-015 SHIFT SHALL process one bit per cycle, LSB first: diff = ai ^ bi ^ bin; bout = (~ai & bi) | (~(ai ^ bi) & bin).
REQ-016 Each difference bit SHALL shift into the result register from the MSB side, so that q is LSB-aligned after WIDTH bits.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; the edge that processes bit WIDTH-1 SHALL move the FSM to DONE.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high during the cycle after edge k+WIDTH+1 and low again after edge k+WIDTH+2.
REQ-019 On the transition to DONE, q, borrow (the final bout) and zero SHALL be loaded together.
REQ-020 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-021 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-022 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-023 A start accepted in the IDLE cycle immediately after DONE SHALL be valid, giving a back-to-back period of WIDTH+2 cycles.
REQ-024 Changes on a or b after acceptance SHALL NOT affect the result in progress.
REQ-025 q, borrow and zero SHALL hold their last published values through IDLE and through the next SHIFT, until the next DONE.
REQ-026 Edge cases: a == b gives q=0, zero=1, borrow=0; a=0, b=2^WIDTH-1 gives q=1, borrow=1.

Reset
REQ-027 While rst=1, the FSM SHALL go to IDLE, and busy, done, q, borrow, zero, the counter and the internal borrow flop SHALL all clear to 0.
REQ-028 rst SHALL take priority over start.
REQ-029 rst asserted in SHIFT or DONE SHALL abort the operation with no done pulse and no partial result.
REQ-030 After rst deasserts, the first start SHALL be accepted normally.

Structure
REQ-031 A shared package serial_sub_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the constant SUB_WIDTH_DEFAULT = 4.
REQ-032 The 1-bit difference/borrow logic SHALL be a sub-module full_subtractor (ports: ai, bi, bin, d, bout), instantiated once.
REQ-033 The counter SHALL be sized $clog2(WIDTH+1) bits.

Verification
REQ-034 Reset, then a=0, b=0, start -> after 6 cycles: done pulse, q=0, zero=1, borrow=0.
REQ-035 WIDTH=4; a=5, b=A -> q=B, borrow=1, zero=0. a=A, b=5 -> q=5, borrow=0. a=F, b=F -> q=0, zero=1.
REQ-036 a=7, b=A with start, then a=1, b=F driven while busy and start re-pulsed -> result q=D, borrow=1; second start ignored.
REQ-037 Back-to-back: start a=1, b=F, then start a=F, b=1 in the first IDLE cycle after done -> q=2/borrow=1, then q=E/borrow=0; done pulses 6 cycles apart.
REQ-038 rst asserted 2 cycles into SHIFT -> busy=0 and q=0 next cycle, no done; a following start with a=9, b=3 -> q=6.
REQ-039 Exhaustive self-check of all 256 (a, b) pairs at WIDTH=4 against (a - b) mod 16, a < b and q == 0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = ai - bi - bin, with borrow out.
module full_subtractor (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = ai ^ bi ^ bin;
  assign bout = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per cycle, LSB first, WIDTH+2 cycle period.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             borrow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  sub_state_t       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             bin_r;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh;
  logic [WIDTH-1:0] d_nxt;
  logic             diff, bout;
  logic             last_bit;

  full_subtractor u_fs (
    .ai  (a_sh[0]),
    .bi  (b_sh[0]),
    .bin (bin_r),
    .d   (diff),
    .bout(bout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  // Difference bits enter from the MSB so the word is LSB-aligned after WIDTH shifts.
  assign d_nxt    = {diff, d_sh[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bin_r  <= 1'b0;
      done   <= 1'b0;
      q      <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      // done trails the DONE state by one edge, giving the documented latency.
      done  <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          cnt   <= '0;
          bin_r <= 1'b0;
        end
        SHIFT: begin
          cnt   <= cnt + CW'(1);
          bin_r <= bout;
          if (last_bit) begin
            q      <= d_nxt;
            borrow <= bout;
            zero   <= (d_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= d_nxt;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 with an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 4;
  localparam int LAT = W + 1;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow, zero;
  logic [W-1:0] q;

  int tests_run = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .borrow(borrow), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_q(input int x, input int y);
    ref_q = W'((x - y) & MASK);
  endfunction

  // Pulse start for one edge, then wait (bounded) for done; lat=-1 on timeout.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] rq, output logic rb, output logic rz,
                       output int lat);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    rq = 'x; rb = 1'bx; rz = 1'bx;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (done) begin
        lat = j; rq = q; rb = borrow; rz = zero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 4'h9; b = 4'h2;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, q, borrow, zero} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h borrow=%b zero=%b, want all 0",
               busy, done, q, borrow, zero);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_priority: busy=%b after reset with start held, want 0", busy);
    end
  endtask

  task automatic test_zero();
    logic [W-1:0] rq; logic rb, rz; int lat;
    do_op(4'h0, 4'h0, rq, rb, rz, lat);
    tests_run++;
    if (lat !== LAT || rq !== 4'h0 || rz !== 1'b1 || rb !== 1'b0) begin
      fails++;
      $display("FAIL zero_op: lat=%0d q=%h borrow=%b zero=%b, want lat=%0d q=0 borrow=0 zero=1",
               lat, rq, rb, rz, LAT);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_width: done=%b one cycle after pulse, want 0", done);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{4'h5, 4'hA, 4'hF};
    logic [W-1:0] vb [3] = '{4'hA, 4'h5, 4'hF};
    logic [W-1:0] rq; logic rb, rz; int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], rq, rb, rz, lat);
      tests_run++;
      if (lat !== LAT || rq !== ref_q(va[i], vb[i]) || rb !== (va[i] < vb[i]) ||
          rz !== (ref_q(va[i], vb[i]) == 0)) begin
        fails++;
        $display("FAIL vector_%0d: a=%h b=%h got lat=%0d q=%h borrow=%b zero=%b, want lat=%0d q=%h borrow=%b zero=%b",
                 i, va[i], vb[i], lat, rq, rb, rz, LAT, ref_q(va[i], vb[i]),
                 va[i] < vb[i], ref_q(va[i], vb[i]) == 0);
      end
    end
    do_op(4'h0, 4'hF, rq, rb, rz, lat);
    tests_run++;
    if (rq !== 4'h1 || rb !== 1'b1 || rz !== 1'b0) begin
      fails++;
      $display("FAIL edge_0_minus_max: got q=%h borrow=%b zero=%b, want q=1 borrow=1 zero=0", rq, rb, rz);
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    int extra = 0;
    @(negedge clk);
    a = 4'h7; b = 4'hA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_accept: busy=%b, want 1", busy);
    end
    @(negedge clk);
    a = 4'h1; b = 4'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 3; j <= 20; j++) begin
      @(negedge clk);
      if (done) begin lat = j; break; end
    end
    tests_run++;
    if (lat !== LAT || q !== 4'hD || borrow !== 1'b1) begin
      fails++;
      $display("FAIL operand_isolation: lat=%0d q=%h borrow=%b, want lat=%0d q=d borrow=1",
               lat, q, borrow, LAT);
    end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL no_queuing: %0d busy/done cycles after ignored start, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1;
    logic [W-1:0] q1, q2;
    logic b1, b2;
    @(negedge clk);
    a = 4'h1; b = 4'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (done && t1 < 0) begin
        t1 = j; q1 = q; b1 = borrow;
        a = 4'hF; b = 4'h1; start = 1'b1;
      end else begin
        start = 1'b0;
        if (done && t1 >= 0) begin t2 = j; q2 = q; b2 = borrow; break; end
      end
    end
    tests_run++;
    if (t1 !== LAT || q1 !== 4'h2 || b1 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: t=%0d q=%h borrow=%b, want t=%0d q=2 borrow=1", t1, q1, b1, LAT);
    end
    tests_run++;
    if (t2 - t1 !== W + 2 || q2 !== 4'hE || b2 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: spacing=%0d q=%h borrow=%b, want spacing=%0d q=e borrow=0",
               t2 - t1, q2, b2, W + 2);
    end
  endtask

  task automatic test_abort();
    int seen = 0;
    logic [W-1:0] rq; logic rb, rz; int lat;
    @(negedge clk);
    a = 4'hC; b = 4'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || q !== '0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_clear: busy=%b q=%h done=%b, want 0 0 0", busy, q, done);
    end
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (done) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL abort_no_done: %0d done pulses after abort, want 0", seen);
    end
    do_op(4'h9, 4'h3, rq, rb, rz, lat);
    tests_run++;
    if (lat !== LAT || rq !== 4'h6 || rb !== 1'b0) begin
      fails++;
      $display("FAIL after_abort: lat=%0d q=%h borrow=%b, want lat=%0d q=6 borrow=0", lat, rq, rb, LAT);
    end
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] rq; logic rb, rz; int lat;
    for (int x = 0; x <= MASK; x++) begin
      for (int y = 0; y <= MASK; y++) begin
        do_op(W'(x), W'(y), rq, rb, rz, lat);
        tests_run++;
        if (lat !== LAT || rq !== ref_q(x, y) || rb !== (x < y) || rz !== (ref_q(x, y) == 0)) begin
          fails++;
          $display("FAIL exhaustive a=%h b=%h: lat=%0d q=%h borrow=%b zero=%b, want lat=%0d q=%h borrow=%b zero=%b",
                   x, y, lat, rq, rb, rz, LAT, ref_q(x, y), x < y, ref_q(x, y) == 0);
        end
      end
    end
  endtask

  // Random operations with operand noise while busy; also checks results hold during SHIFT.
  task automatic test_random();
    logic [W-1:0] prev_q;
    logic [W-1:0] x, y;
    int lat;
    for (int n = 0; n < 40; n++) begin
      prev_q = q;
      x = W'($urandom_range(0, MASK));
      y = W'($urandom_range(0, MASK));
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int j = 1; j <= 20; j++) begin
        a = W'($urandom); b = W'($urandom); start = 1'($urandom);
        @(negedge clk);
        if (j == 2) begin
          tests_run++;
          if (q !== prev_q) begin
            fails++;
            $display("FAIL hold_in_shift: q=%h, want previous %h", q, prev_q);
          end
        end
        if (done) begin lat = j; break; end
      end
      start = 1'b0;
      tests_run++;
      if (lat !== LAT || q !== ref_q(x, y) || borrow !== (x < y) || zero !== (ref_q(x, y) == 0)) begin
        fails++;
        $display("FAIL random a=%h b=%h: lat=%0d q=%h borrow=%b zero=%b, want lat=%0d q=%h borrow=%b zero=%b",
                 x, y, lat, q, borrow, zero, LAT, ref_q(x, y), x < y, ref_q(x, y) == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_exhaustive();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
